// File: rtl/ps2_pkg.sv
// Shared constants, event type, state encodings and the hex-to-ASCII helper
// for the PS/2 key reporter.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  localparam int EVENT_W = $bits(key_event_t);

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  typedef enum logic [3:0] {
    SER_IDLE,
    SER_E0H,
    SER_E0L,
    SER_F0H,
    SER_F0L,
    SER_CH,
    SER_CL,
    SER_END1,
    SER_END2
  } ser_state_t;

  // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead FIFO for key events: synchronous push/pop, registered level,
// and a one-cycle pulse when a push is refused because the FIFO is full.
module key_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      level_reg;
  logic             dropped_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level_reg == '0);
  assign full     = (level_reg == FULL_LEVEL);
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign level    = level_reg;
  assign dropped  = dropped_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_reg   <= '0;
      dropped_reg <= 1'b0;
    end else begin
      dropped_reg <= push & ~do_push;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_reporter.sv
// Decodes E0/F0-prefixed PS/2 scan bytes into key events, optionally drops
// typematic repeats, queues them and prints each as an uppercase-hex line.
module ps2_key_reporter
  import ps2_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter bit FILTER_REPEAT = 1'b1,
  parameter bit CRLF          = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  dec_state_t dec_state;
  dec_state_t dec_next;
  key_event_t dec_event;
  logic       dec_emit;

  logic       held_valid;
  logic       held_ext;
  logic [7:0] held_code;
  logic       held_match;
  logic       push;

  logic [EVENT_W-1:0] pop_data;
  key_event_t         pop_event;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;

  ser_state_t ser_state;
  ser_state_t ser_next;
  key_event_t line_event;
  logic [7:0] char_data;
  logic       char_valid;

  // Prefix decoder
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dec_state <= DEC_IDLE;
    else     dec_state <= dec_next;
  end

  always_comb begin
    dec_next       = dec_state;
    dec_emit       = 1'b0;
    dec_event.ext  = 1'b0;
    dec_event.brk  = 1'b0;
    dec_event.code = byte_in;
    if (byte_valid) begin
      if (byte_in == PS2_EXT) begin
        dec_next = DEC_EXT;
      end else if (byte_in == PS2_BRK) begin
        case (dec_state)
          DEC_EXT, DEC_EXT_BRK: dec_next = DEC_EXT_BRK;
          default:              dec_next = DEC_BRK;
        endcase
      end else begin
        dec_emit      = 1'b1;
        dec_event.ext = (dec_state == DEC_EXT) || (dec_state == DEC_EXT_BRK);
        dec_event.brk = (dec_state == DEC_BRK) || (dec_state == DEC_EXT_BRK);
        dec_next      = DEC_IDLE;
      end
    end
  end

  // Repeat filter: remembers the last make so auto-repeats of it are dropped.
  assign held_match = held_valid && (held_ext == dec_event.ext) &&
                      (held_code == dec_event.code);
  assign push = dec_emit && !(FILTER_REPEAT && !dec_event.brk && held_match);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= 8'h00;
    end else if (FILTER_REPEAT && dec_emit) begin
      if (!dec_event.brk) begin
        if (!held_match) begin
          held_valid <= 1'b1;
          held_ext   <= dec_event.ext;
          held_code  <= dec_event.code;
        end
      end else if (held_match) begin
        held_valid <= 1'b0;
      end
    end
  end

  key_event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (dec_event),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .dropped   (overflow)
  );

  assign pop_event = pop_data;

  // Line serialiser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_state  <= SER_IDLE;
      line_event <= '0;
    end else begin
      ser_state <= ser_next;
      if (pop) line_event <= pop_event;
    end
  end

  always_comb begin
    ser_next   = ser_state;
    pop        = 1'b0;
    char_valid = 1'b1;
    char_data  = 8'h00;
    case (ser_state)
      SER_IDLE: begin
        char_valid = 1'b0;
        if (!fifo_empty) begin
          pop = 1'b1;
          if (pop_event.ext)      ser_next = SER_E0H;
          else if (pop_event.brk) ser_next = SER_F0H;
          else                    ser_next = SER_CH;
        end
      end
      SER_E0H: begin
        char_data = nib2ascii(4'hE);
        if (out_ready) ser_next = SER_E0L;
      end
      SER_E0L: begin
        char_data = nib2ascii(4'h0);
        if (out_ready) ser_next = line_event.brk ? SER_F0H : SER_CH;
      end
      SER_F0H: begin
        char_data = nib2ascii(4'hF);
        if (out_ready) ser_next = SER_F0L;
      end
      SER_F0L: begin
        char_data = nib2ascii(4'h0);
        if (out_ready) ser_next = SER_CH;
      end
      SER_CH: begin
        char_data = nib2ascii(line_event.code[7:4]);
        if (out_ready) ser_next = SER_CL;
      end
      SER_CL: begin
        char_data = nib2ascii(line_event.code[3:0]);
        if (out_ready) ser_next = SER_END1;
      end
      SER_END1: begin
        char_data = CRLF ? ASCII_CR : ASCII_SP;
        if (out_ready) ser_next = CRLF ? SER_END2 : SER_IDLE;
      end
      SER_END2: begin
        char_data = ASCII_LF;
        if (out_ready) ser_next = SER_IDLE;
      end
      default: begin
        char_valid = 1'b0;
        ser_next   = SER_IDLE;
      end
    endcase
  end

  assign out_valid = char_valid;
  assign out_data  = char_data;

endmodule
